vnu_param: RTL and testbench



---
 rtl/ldpc_pkg.sv | 50 +++++
 rtl/vnu_sat_sm.sv | 20 ++
 rtl/vnu_param.sv | 117 +++++++++++
 tb/tb_vnu_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg - shared helpers for the LDPC min-sum decoder datapath.
//   vnu_sum_width : internal two's-complement sum width for a variable node
//   sm_to_tc      : sign-magnitude -> two's complement (negative zero -> 0)
//   tc_to_sm_sat  : two's complement -> symmetric-saturated sign-magnitude
// Helpers work on 32-bit containers; callers size-cast to their own widths.
package ldpc_pkg;

    localparam int unsigned WIDE_W = 32;

    // Generic container for messages before they are cut to their final width.
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough for DV+1 terms of the larger operand without overflow,
    // plus one bit of headroom for the extrinsic subtraction.
    function automatic int unsigned vnu_sum_width(input int unsigned dv,
                                                  input int unsigned mw,
                                                  input int unsigned zw);
        return max_u(mw, zw + 1) + $clog2(dv + 1) + 1;
    endfunction

    // Magnitude arrives zero-extended; negating a zero magnitude yields 0,
    // so negative zero needs no special case.
    function automatic wide_t sm_to_tc(input logic sign, input logic [WIDE_W-1:0] mag);
        wide_t m;
        m = wide_t'(mag);
        return sign ? -m : m;
    endfunction

    // Clamp to +/-(2^(ow-1)-1) so the result is representable in sign-magnitude;
    // zero is emitted with the sign bit clear.
    function automatic logic [WIDE_W-1:0] tc_to_sm_sat(input wide_t v, input int unsigned ow);
        wide_t             lim;
        logic              s;
        logic [WIDE_W-1:0] mag;
        lim = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        if (v < 0) begin
            s   = 1'b1;
            mag = (-v > lim) ? lim : -v;
        end else begin
            s   = 1'b0;
            mag = (v > lim) ? lim : v;
        end
        return (WIDE_W'(s) << (ow - 1)) | mag;
    endfunction

endpackage

// File: rtl/vnu_sat_sm.sv
// vnu_sat_sm - combinational saturation and two's complement to
// sign-magnitude conversion for one extrinsic message.
// Ports:
//   val : SW-bit two's complement extrinsic value
//   sm  : OW-bit sign-magnitude result, MSB = sign, never negative zero
module vnu_sat_sm
    import ldpc_pkg::*;
#(
    parameter int unsigned SW = 9,
    parameter int unsigned OW = 6
) (
    input  logic [SW-1:0] val,
    output logic [OW-1:0] sm
);

    always_comb begin
        sm = OW'(tc_to_sm_sat(WIDE_W'(signed'(val)), OW));
    end

endmodule

// File: rtl/vnu_param.sv
// vnu_param - parametrised variable node unit for the LDPC min-sum decoder.
// Two-stage valid-tracked pipeline: stage 1 converts the DV check messages to
// two's complement and forms the total LLR; stage 2 forms the extrinsic
// messages (total - own input), saturates them and encodes sign-magnitude.
// Optional build macro VNU_EDGE_MASK_EN adds a per-edge mask input.
// Ports:
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   en            : pipeline advance; 0 holds every register
//   in_valid      : X/Z carry a valid update
//   X             : DV packed sign-magnitude messages, edge i at [i*MW +: MW]
//   Z             : ZW-bit two's complement intrinsic LLR
//   edge_mask     : (VNU_EDGE_MASK_EN only) 1 = edge inactive
//   out_valid     : Y/hard_decision valid
//   Y             : DV packed sign-magnitude extrinsics, edge i at [i*OW +: OW]
//   hard_decision : 1 when the total LLR is negative
module vnu_param
    import ldpc_pkg::*;
#(
    parameter int unsigned DV = 3,
    parameter int unsigned MW = 5,
    parameter int unsigned ZW = 5,
    parameter int unsigned OW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [DV*MW-1:0] X,
    input  logic [ZW-1:0]    Z,
`ifdef VNU_EDGE_MASK_EN
    input  logic [DV-1:0]    edge_mask,
`endif
    output logic             out_valid,
    output logic [DV*OW-1:0] Y,
    output logic             hard_decision
);

    localparam int unsigned SW = vnu_sum_width(DV, MW, ZW);

    logic [DV-1:0]          mask_s;
    logic [DV-1:0][SW-1:0]  x_tc_d;
    logic [SW-1:0]          total_d;

    logic                   v1;
    logic [DV-1:0]          mask_q;
    logic [DV-1:0][SW-1:0]  x_tc_q;
    logic [SW-1:0]          total_q;

    logic [DV-1:0][SW-1:0]  ext;
    logic [DV-1:0][OW-1:0]  ext_sm;
    logic [DV*OW-1:0]       y_d;

`ifdef VNU_EDGE_MASK_EN
    assign mask_s = edge_mask;
`else
    assign mask_s = '0;
`endif

    // Stage 1: masked edges enter the sum as 0 so the total excludes them.
    always_comb begin
        total_d = SW'(signed'(Z));
        for (int unsigned i = 0; i < DV; i++) begin
            if (mask_s[i]) begin
                x_tc_d[i] = '0;
            end else begin
                x_tc_d[i] = SW'(sm_to_tc(X[i*MW + MW - 1], WIDE_W'(X[i*MW +: MW-1])));
            end
            total_d = total_d + x_tc_d[i];
        end
    end

    // Stage 2: extrinsic = total minus this edge's own contribution.
    always_comb begin
        for (int unsigned i = 0; i < DV; i++) begin
            ext[i] = total_q - x_tc_q[i];
        end
    end

    for (genvar g = 0; g < DV; g++) begin : g_sat
        vnu_sat_sm #(
            .SW (SW),
            .OW (OW)
        ) u_sat (
            .val (ext[g]),
            .sm  (ext_sm[g])
        );
    end

    always_comb begin
        y_d = '0;
        for (int unsigned i = 0; i < DV; i++) begin
            y_d[i*OW +: OW] = mask_q[i] ? '0 : ext_sm[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            mask_q        <= '0;
            x_tc_q        <= '0;
            total_q       <= '0;
            out_valid     <= 1'b0;
            Y             <= '0;
            hard_decision <= 1'b0;
        end else if (en) begin
            v1            <= in_valid;
            mask_q        <= mask_s;
            x_tc_q        <= x_tc_d;
            total_q       <= total_d;
            out_valid     <= v1;
            Y             <= y_d;
            hard_decision <= total_q[SW-1];
        end
    end

endmodule

// File: tb/tb_vnu_param.sv
// tb_vnu_param - scoreboard bench for vnu_param (DV=3, MW=5, ZW=5, OW=6).
// Expected results come from an integer model at drive time and are popped
// when the DUT presents a result on an en=1 edge.
module tb_vnu_param;

    localparam int unsigned DV = 3;
    localparam int unsigned MW = 5;
    localparam int unsigned ZW = 5;
    localparam int unsigned OW = 6;

    typedef struct {
        logic [DV*OW-1:0] y;
        logic             hd;
        int               t;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic [DV*MW-1:0] X;
    logic [ZW-1:0]    Z;
    logic [DV-1:0]    mask;
    logic             out_valid;
    logic [DV*OW-1:0] Y;
    logic             hard_decision;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;
    logic mon_en;

    vnu_param #(
        .DV (DV),
        .MW (MW),
        .ZW (ZW),
        .OW (OW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .in_valid      (in_valid),
        .X             (X),
        .Z             (Z),
`ifdef VNU_EDGE_MASK_EN
        .edge_mask     (mask),
`endif
        .out_valid     (out_valid),
        .Y             (Y),
        .hard_decision (hard_decision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [DV*MW-1:0] x, input logic [ZW-1:0] z,
                                   input logic [DV-1:0] m, input int t);
        exp_t          r;
        int            tot;
        int            v [DV];
        int            mag;
        int            e;
        int            enc;
        int            lim;
        logic [DV-1:0] me;
`ifdef VNU_EDGE_MASK_EN
        me = m;
`else
        me = '0;
`endif
        lim = (1 << (OW - 1)) - 1;
        tot = int'($signed(z));
        for (int i = 0; i < DV; i++) begin
            mag  = int'(x[i*MW +: MW-1]);
            v[i] = me[i] ? 0 : (x[i*MW + MW - 1] ? -mag : mag);
            tot += v[i];
        end
        r.y = '0;
        for (int i = 0; i < DV; i++) begin
            e = tot - v[i];
            if (e > lim)  e = lim;
            if (e < -lim) e = -lim;
            enc = (e < 0) ? ((1 << (OW - 1)) | -e) : e;
            if (me[i]) enc = 0;
            r.y[i*OW +: OW] = enc[OW-1:0];
        end
        r.hd = (tot < 0);
        r.t  = t;
        return r;
    endfunction

    task automatic send(input logic [DV*MW-1:0] x, input logic [ZW-1:0] z,
                        input logic [DV-1:0] m, input logic v, input logic e);
        @(negedge clk);
        X        = x;
        Z        = z;
        mask     = m;
        in_valid = v;
        en       = e;
        if (v && e) sb.push_back(model(x, z, m, ecnt));
    endtask

    function automatic logic [DV*MW-1:0] pack3(input logic [MW-1:0] x0,
                                               input logic [MW-1:0] x1,
                                               input logic [MW-1:0] x2);
        return {x2, x1, x0};
    endfunction

    // Results are consumed only on en=1 edges; a held out_valid is not a new result.
    always @(posedge clk) begin
        exp_t e;
        mon_en = en;
        #1;
        if (mon_en) ecnt++;
        if (rst_n && mon_en && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("y", Y, e.y);
                check("hard_decision", hard_decision, e.hd);
                check("latency", 64'(ecnt - e.t), 64'd2);
                last = e;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        X        = '0;
        Z        = '0;
        mask     = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", Y, '0);
        check("rst_hd", hard_decision, 1'b0);
        rst_n = 1'b1;

        // Directed vectors, back to back.
        send(pack3(5'b00010, 5'b10001, 5'b00100), 5'd3, '0, 1'b1, 1'b1);
        send(pack3(5'b01111, 5'b01111, 5'b01111), 5'b01111, '0, 1'b1, 1'b1);
        send(pack3(5'b11111, 5'b11111, 5'b11111), 5'b10001, '0, 1'b1, 1'b1);
        send(pack3(5'b10000, 5'b00000, 5'b10000), 5'd0, '0, 1'b1, 1'b1);
        send(pack3(5'b00001, 5'b00001, 5'b00000), 5'b11110, '0, 1'b1, 1'b1);
        repeat (4) send('0, '0, '0, 1'b0, 1'b1);

        // Stall after two valids: outputs must hold the first result.
        send(pack3(5'b00011, 5'b10010, 5'b00001), 5'b11101, '0, 1'b1, 1'b1);
        send(pack3(5'b00111, 5'b00110, 5'b10101), 5'd6, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(pack3(5'b01010, 5'b01010, 5'b01010), 5'd1, '0, 1'b1, 1'b0);
            @(posedge clk);
            #2;
            check("stall_valid", out_valid, 1'b1);
            check("stall_y", Y, last.y);
            check("stall_hd", hard_decision, last.hd);
        end
        send(pack3(5'b11000, 5'b00101, 5'b01100), 5'b11000, '0, 1'b1, 1'b1);
        send(pack3(5'b00000, 5'b11110, 5'b01001), 5'd2, '0, 1'b1, 1'b1);
        repeat (4) send('0, '0, '0, 1'b0, 1'b1);

        // Edge mask (inert in the default build).
        send(pack3(5'b00010, 5'b10001, 5'b00100), 5'd3, 3'b100, 1'b1, 1'b1);
        send(pack3(5'b01111, 5'b10111, 5'b00011), 5'b11001, 3'b011, 1'b1, 1'b1);
        repeat (4) send('0, '0, '0, 1'b0, 1'b1);

        // Asynchronous reset with two updates in flight.
        send(pack3(5'b01111, 5'b01111, 5'b01111), 5'b01111, '0, 1'b1, 1'b1);
        send(pack3(5'b11111, 5'b11111, 5'b11111), 5'b10001, '0, 1'b1, 1'b1);
        send(pack3(5'b01111, 5'b01111, 5'b01111), 5'b01111, '0, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_y", Y, '0);
        check("arst_hd", hard_decision, 1'b0);
        sb.delete();
        repeat (2) send('0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (5) send('0, '0, '0, 1'b0, 1'b1);

        // Random stream with random stalls and gaps.
        for (int i = 0; i < 60; i++) begin
            send(DV*MW'($urandom), ZW'($urandom), DV'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end
        repeat (6) send('0, '0, '0, 1'b0, 1'b1);

        check("drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
